spike_shape: RTL and testbench
==============================

# spike_shape

Parameterised shape-drawer feeding the game control stage: one instance per obstacle slot (Spike_1..Spike_5). On a `draw_start` request it streams every pixel of a filled isosceles spike, one per clock, on `x`/`y`/`colour`, then raises `draw_done`. Between draws it scrolls its own horizontal position left by `SPEED` on each `update_screen` frame pulse. Control multiplexes these outputs into the VGA adapter.

## Interface
- `START_X`, 11'd160: x of the spike's base-left column after reset or wrap.
- `BASE_Y`, 11'd100: y of the base (bottom) row.
- `HEIGHT`, 8: rows in the spike, ≥1. The base is 2·HEIGHT−1 wide and there are HEIGHT² pixels. `START_X+2·HEIGHT−2 ≤ 2047` and `BASE_Y ≥ HEIGHT−1`.
- `COLOUR`, 3'b100: pixel colour.
- `SPEED`, 11'd1: columns moved per frame, ≥1.
- `clock`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `position_reset`  in  1  synchronous, active-high game reset from control.
- `update_screen`  in  1  single-cycle frame tick.
- `draw_start`  in  1  level draw request; control holds it until it sees `draw_done`, or longer.
- `draw_done`  out  1  registered; high while the draw is complete.
- `x`  out  11  registered pixel x.
- `y`  out  11  registered pixel y.
- `colour`  out  3  registered pixel colour.

## Operation
- State: `x_pos` (11 b), `row` and `col` counters, `move_pending` flag, FSM IDLE / DRAW / DONE.
- `resetn` low (async) sets:
  - IDLE, `x_pos=START_X`, `row=col=0`, `move_pending=0`;
  - `draw_done=0`, `x=0`, `y=0`, `colour=0`.
- `position_reset` high has the highest synchronous priority, from any state. It forces IDLE with `x_pos=START_X`, counters 0, `move_pending=0` and `draw_done=0`. Outputs hold. `draw_start` is ignored while it is high.
- **IDLE:**
  - If `update_screen` or `move_pending` is set, apply a move and clear `move_pending`.
  - A move is `x_pos <= (x_pos < SPEED) ? START_X : x_pos − SPEED`.
  - If `draw_start` is also high, go to DRAW with `row=col=0`. The move still applies and the draw uses the new `x_pos`.
- **DRAW:** each cycle registers one pixel from the current counters, then advances them.
  - `x <= x_pos + (HEIGHT−1) − row + col`.
  - `y <= BASE_Y − (HEIGHT−1) + row`.
  - `colour <= COLOUR`.
  - Advance: if `col == 2·row`, then `col<=0` and `row<=row+1`; otherwise `col<=col+1`.
  - Last pixel is `row==HEIGHT−1`, `col==2·HEIGHT−2`. It is registered together with `draw_done<=1`, and the FSM goes to DONE.
  - `update_screen` seen during DRAW or DONE sets `move_pending`; the move is never applied mid-draw.
  - `draw_start` falling during DRAW does not abort; the draw completes.
- **DONE:**
  - `draw_done` stays high and `x`/`y`/`colour` hold the last pixel.
  - When `draw_start` is low: `draw_done<=0`, go to IDLE. The pending move applies on the following IDLE cycle.
  - If `draw_start` stays high, remain in DONE indefinitely. This covers the last spike slot, which control holds on.
- Arithmetic: all coordinates are 11-bit unsigned; the parameter constraints guarantee no overflow. Off-screen x (≥160) is emitted unclipped; the VGA adapter discards it.

## Timing
- Edge k is the IDLE edge that samples `draw_start=1`.
- Pixel n (0 ≤ n < HEIGHT²) is on the outputs from edge k+1+n, for exactly one cycle, except the last pixel, which holds.
- `draw_done` rises at edge k+HEIGHT², coincident with the last pixel.
- Total request-to-done latency is HEIGHT² cycles; this is 64 at defaults.
- If `draw_start` falls at edge m (observed in DONE), `draw_done` falls at edge m+1. The earliest restart is edge m+2.
- Move latency:
  - In IDLE, `x_pos` updates on the same edge that samples `update_screen`.
  - Otherwise it updates on the first IDLE edge after the draw.
  - Multiple ticks during one draw collapse into a single move.

## Test plan
- Defaults, reset, then `draw_start` held:
  - first pixel (167,93), colour 3'b100;
  - second pixel (166,94), third (167,94);
  - last pixel (174,100);
  - `draw_done` at exactly 64 edges after the DRAW entry; 64 distinct pixels, none repeated.
- Drop `draw_start` after `draw_done`: `draw_done` low one edge later. Reassert: identical 64-pixel sequence.
- Pulse `update_screen` 3 times in IDLE, then draw: first pixel (164,93).
- Pulse `update_screen` twice during DRAW: pixel stream unchanged. After return to IDLE, `x_pos` has decremented by exactly 1. The next draw starts at x=166.
- 160 ticks give `x_pos=0`; the first pixel is at x=7. The 161st tick gives `x_pos=160`.
- Assert `position_reset` at pixel 20:
  - IDLE next edge, `draw_done=0`, `x_pos=160`;
  - a new draw restarts at (167,93).
- Assert `resetn` low mid-draw: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spike_shape.sv
// spike_shape: streams every pixel of a filled isosceles spike on request,
// one per clock, and scrolls its own x position left once per frame between draws.
module spike_shape #(
   parameter logic [10:0] START_X = 11'd160,
   parameter logic [10:0] BASE_Y  = 11'd100,
   parameter int unsigned HEIGHT  = 8,
   parameter logic [2:0]  COLOUR  = 3'b100,
   parameter logic [10:0] SPEED   = 11'd1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        position_reset,
   input  logic        update_screen,
   input  logic        draw_start,
   output logic        draw_done,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [2:0]  colour
);

   localparam logic [10:0] H_M1     = 11'(HEIGHT - 1);
   localparam logic [10:0] LAST_COL = 11'(2 * HEIGHT - 2);
   localparam logic [10:0] TOP_Y    = BASE_Y - H_M1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [10:0] x_pos_r;
   logic [10:0] row_r;
   logic [10:0] col_r;
   logic        move_pending_r;

   logic [10:0] moved_x_s;
   logic        last_pixel_s;
   logic        row_end_s;

   // Wrap back to the start column instead of underflowing past the left edge.
   assign moved_x_s    = (x_pos_r < SPEED) ? START_X : (x_pos_r - SPEED);
   assign last_pixel_s = (row_r == H_M1) && (col_r == LAST_COL);
   assign row_end_s    = (col_r == {row_r[9:0], 1'b0});

   // Draw sequencer, position scroller and registered pixel outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r        <= IDLE;
         x_pos_r        <= START_X;
         row_r          <= 11'd0;
         col_r          <= 11'd0;
         move_pending_r <= 1'b0;
         draw_done      <= 1'b0;
         x              <= 11'd0;
         y              <= 11'd0;
         colour         <= 3'd0;
      end else if (position_reset) begin
         state_r        <= IDLE;
         x_pos_r        <= START_X;
         row_r          <= 11'd0;
         col_r          <= 11'd0;
         move_pending_r <= 1'b0;
         draw_done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (update_screen || move_pending_r) begin
                  x_pos_r <= moved_x_s;
               end
               move_pending_r <= 1'b0;
               if (draw_start) begin
                  state_r <= DRAW;
                  row_r   <= 11'd0;
                  col_r   <= 11'd0;
               end
            end
            DRAW: begin
               x              <= x_pos_r + H_M1 - row_r + col_r;
               y              <= TOP_Y + row_r;
               colour         <= COLOUR;
               move_pending_r <= move_pending_r | update_screen;
               if (last_pixel_s) begin
                  draw_done <= 1'b1;
                  state_r   <= DONE;
               end else if (row_end_s) begin
                  col_r <= 11'd0;
                  row_r <= row_r + 11'd1;
               end else begin
                  col_r <= col_r + 11'd1;
               end
            end
            DONE: begin
               move_pending_r <= move_pending_r | update_screen;
               if (!draw_start) begin
                  draw_done <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               draw_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_shape.sv
// Self-checking bench for spike_shape: a pixel-index behavioural model checked
// every cycle, plus directed scenarios with hand-computed pixel coordinates.
module tb_spike_shape;

   localparam int H    = 8;
   localparam int NPIX = H * H;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        position_reset = 1'b0;
   logic        update_screen = 1'b0;
   logic        draw_start = 1'b0;
   logic        draw_done;
   logic [10:0] x;
   logic [10:0] y;
   logic [2:0]  colour;

   int checks = 0;
   int failures = 0;

   spike_shape dut (
      .clock(clock),
      .resetn(resetn),
      .position_reset(position_reset),
      .update_screen(update_screen),
      .draw_start(draw_start),
      .draw_done(draw_done),
      .x(x),
      .y(y),
      .colour(colour)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Triangle geometry: pixel n -> offset from (x_pos, top row), rows top-down, left to right.
   int dx [NPIX];
   int dy [NPIX];

   // Behavioural model: mode 0 idle, 1 drawing pixel m_n, 2 done.
   int   m_mode = 0;
   int   m_n = 0;
   int   m_xp = 160;
   bit   m_pend = 1'b0;
   int   m_x = 0, m_y = 0, m_c = 0;
   bit   m_done = 1'b0;

   function automatic int mv(input int p);
      return (p < 1) ? 160 : p - 1;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_mode = 0; m_n = 0; m_xp = 160; m_pend = 1'b0;
         m_x = 0; m_y = 0; m_c = 0; m_done = 1'b0;
      end else if (position_reset) begin
         m_mode = 0; m_xp = 160; m_pend = 1'b0; m_done = 1'b0;
      end else if (m_mode == 0) begin
         if (update_screen || m_pend) m_xp = mv(m_xp);
         m_pend = 1'b0;
         if (draw_start) begin
            m_mode = 1; m_n = 0;
         end
      end else if (m_mode == 1) begin
         m_x = m_xp + dx[m_n];
         m_y = 100 - (H - 1) + dy[m_n];
         m_c = 4;
         if (update_screen) m_pend = 1'b1;
         if (m_n == NPIX - 1) begin
            m_done = 1'b1; m_mode = 2;
         end else begin
            m_n++;
         end
      end else begin
         if (update_screen) m_pend = 1'b1;
         if (!draw_start) begin
            m_done = 1'b0; m_mode = 0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clock) begin
      chk("model_x", int'(x), m_x);
      chk("model_y", int'(y), m_y);
      chk("model_colour", int'(colour), m_c);
      chk("model_done", int'(draw_done), int'(m_done));
   end

   int px [NPIX];
   int py [NPIX];
   int refx [NPIX];
   int refy [NPIX];

   // Raise draw_start and record the pixel stream; lat = edges from DRAW entry to draw_done.
   task automatic capture(input int t1, input int t2, output int lat);
      lat = -1;
      draw_start = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clock);
         update_screen = (i == t1) || (i == t2);
         if (i >= 2 && i - 2 < NPIX) begin
            px[i-2] = int'(x);
            py[i-2] = int'(y);
         end
         if (draw_done) begin
            lat = i - 1;
            break;
         end
      end
      update_screen = 1'b0;
      chk("draw_latency", lat, NPIX);
   endtask

   function automatic int stream_diff();
      int bad = 0;
      for (int i = 0; i < NPIX; i++)
         if (px[i] != refx[i] || py[i] != refy[i]) bad++;
      return bad;
   endfunction

   task automatic end_draw();
      draw_start = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      int lat;
      int n;
      int dups;
      n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c <= 2 * r; c++) begin
            dx[n] = H - 1 - r + c;
            dy[n] = r;
            n++;
         end

      repeat (2) @(negedge clock);
      chk("reset_x", int'(x), 0);
      chk("reset_y", int'(y), 0);
      chk("reset_colour", int'(colour), 0);
      chk("reset_done", int'(draw_done), 0);
      resetn = 1'b1;
      @(negedge clock);

      // First draw from the start column.
      capture(0, 0, lat);
      chk("p0_x", px[0], 167);  chk("p0_y", py[0], 93);
      chk("p1_x", px[1], 166);  chk("p1_y", py[1], 94);
      chk("p2_x", px[2], 167);  chk("p2_y", py[2], 94);
      chk("p63_x", px[63], 174); chk("p63_y", py[63], 100);
      dups = 0;
      for (int i = 0; i < NPIX; i++)
         for (int j = i + 1; j < NPIX; j++)
            if (px[i] == px[j] && py[i] == py[j]) dups++;
      chk("distinct_pixels", dups, 0);
      for (int i = 0; i < NPIX; i++) begin
         refx[i] = px[i];
         refy[i] = py[i];
      end
      repeat (3) begin
         @(negedge clock);
         chk("done_hold", int'(draw_done), 1);
         chk("last_hold_x", int'(x), 174);
      end

      // Drop request: done falls one edge later, then redraw identically.
      draw_start = 1'b0;
      @(negedge clock);
      chk("done_fall", int'(draw_done), 0);
      @(negedge clock);
      capture(0, 0, lat);
      chk("stream_repeat", stream_diff(), 0);
      end_draw();

      // Two ticks mid-draw: stream unchanged, one deferred move afterwards.
      capture(10, 30, lat);
      chk("stream_ticks_mid_draw", stream_diff(), 0);
      end_draw();
      capture(0, 0, lat);
      chk("deferred_move_x", px[0], 166);

      // Three idle ticks after a position reset.
      draw_start = 1'b0;
      position_reset = 1'b1;
      @(negedge clock);
      position_reset = 1'b0;
      repeat (3) begin
         update_screen = 1'b1; @(negedge clock);
         update_screen = 1'b0; @(negedge clock);
      end
      capture(0, 0, lat);
      chk("three_ticks_x", px[0], 164);

      // 160 ticks reach x_pos 0; one more wraps to the start column.
      draw_start = 1'b0;
      position_reset = 1'b1;
      @(negedge clock);
      position_reset = 1'b0;
      update_screen = 1'b1;
      repeat (160) @(negedge clock);
      update_screen = 1'b0;
      capture(0, 0, lat);
      chk("xpos0_first_x", px[0], 7);
      chk("xpos0_first_y", py[0], 93);
      draw_start = 1'b0;
      @(negedge clock);
      update_screen = 1'b1; @(negedge clock);
      update_screen = 1'b0; @(negedge clock);
      capture(0, 0, lat);
      chk("wrap_first_x", px[0], 167);

      // position_reset at pixel 20 of a draw from x_pos 158.
      draw_start = 1'b0;
      position_reset = 1'b1;
      @(negedge clock);
      position_reset = 1'b0;
      update_screen = 1'b1;
      repeat (2) @(negedge clock);
      update_screen = 1'b0;
      draw_start = 1'b1;
      repeat (22) @(negedge clock);
      chk("pix20_x", int'(x), 165);
      chk("pix20_y", int'(y), 97);
      position_reset = 1'b1;
      @(negedge clock);
      chk("preset_done", int'(draw_done), 0);
      chk("preset_hold_x", int'(x), 165);
      position_reset = 1'b0;
      capture(0, 0, lat);
      chk("restart_x", px[0], 167);
      chk("restart_y", py[0], 93);
      chk("restart_stream", stream_diff(), 0);

      // Asynchronous reset in the middle of a draw.
      end_draw();
      draw_start = 1'b1;
      repeat (10) @(negedge clock);
      @(posedge clock);
      #2 resetn = 1'b0;
      #1;
      chk("async_x", int'(x), 0);
      chk("async_y", int'(y), 0);
      chk("async_colour", int'(colour), 0);
      chk("async_done", int'(draw_done), 0);
      @(negedge clock);
      draw_start = 1'b0;
      resetn = 1'b1;
      repeat (3) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
